// File: rtl/lcd_line_fetch_ctrl_pkg.sv
// Shared LCD fetch timing constants and FSM state encoding, common to the
// fetch scheduler and the pixel writer so both agree on frame geometry.
package lcd_line_fetch_ctrl_pkg;

    localparam int unsigned DEF_HOR_PIX    = 480;
    localparam int unsigned DEF_VER_PIX    = 272;
    localparam int unsigned DEF_FIFO_DEPTH = 64;
    localparam int unsigned DEF_BURST_LEN  = 16;
    localparam int unsigned DEF_ADDR_W     = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/lcd_line_fetch_ctrl_fifo_credit.sv
// Pixel FIFO occupancy tracker: level from fill/pop events, empty flag,
// saturating underflow count and burst credit.
module lcd_line_fetch_ctrl_fifo_credit
    import lcd_line_fetch_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                             clk_12mhz,
    input  logic                             rst,
    input  logic                             fill,
    input  logic                             pop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             buffer_empty,
    output logic [15:0]                      underflow_cnt,
    output logic                             credit_ok_c
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    assign buffer_empty = (fifo_level == '0);
    assign credit_ok_c  = (32'(fifo_level) + BURST_LEN) <= FIFO_DEPTH;

    // Simultaneous fill and pop cancel, including at level 0.
    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            fifo_level    <= '0;
            underflow_cnt <= '0;
        end else if (fill && !pop) begin
            fifo_level <= fifo_level + LVL_W'(1);
        end else if (!fill && pop) begin
            if (fifo_level == '0) begin
                if (underflow_cnt != 16'hFFFF)
                    underflow_cnt <= underflow_cnt + 16'd1;
            end else begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_line_fetch_ctrl.sv
// Frame-fetch scheduler: walks the framebuffer in fixed bursts, gated by
// pixel FIFO credit, and reports frame progress and protocol errors.
module lcd_line_fetch_ctrl
    import lcd_line_fetch_ctrl_pkg::*;
#(
    parameter int unsigned HOR_PIX    = DEF_HOR_PIX,
    parameter int unsigned VER_PIX    = DEF_VER_PIX,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                             clk_12mhz,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             frame_start,
    input  logic [ADDR_W-1:0]                fb_base,
    output logic                             rd_req,
    output logic [ADDR_W-1:0]                rd_addr,
    input  logic                             rd_ack,
    input  logic                             rd_data_valid,
    input  logic                             fifo_pop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             buffer_empty,
    output logic                             frame_busy,
    output logic                             frame_done,
    output logic [15:0]                      line_index,
    output logic [15:0]                      underflow_cnt,
    output logic                             err_overrun,
    output logic                             err_extra
);
    localparam int unsigned TOTAL  = HOR_PIX * VER_PIX;
    localparam int unsigned WORD_W = $clog2(TOTAL + 1);
    localparam int unsigned COL_W  = (HOR_PIX > 1) ? $clog2(HOR_PIX) : 1;
    localparam int unsigned OUT_W  = $clog2(BURST_LEN + 1);

    fetch_state_e        state;
    logic [OUT_W-1:0]    outstanding;
    logic [WORD_W-1:0]   word_cnt;
    logic [COL_W-1:0]    col_cnt;
    logic                credit_ok_c;
    logic                word_in_c;
    logic                burst_end_c;
    logic                frame_end_c;
    logic                start_ok_c;

    lcd_line_fetch_ctrl_fifo_credit #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_LEN  (BURST_LEN)
    ) u_credit (
        .clk_12mhz     (clk_12mhz),
        .rst           (rst),
        .fill          (rd_data_valid),
        .pop           (fifo_pop),
        .fifo_level    (fifo_level),
        .buffer_empty  (buffer_empty),
        .underflow_cnt (underflow_cnt),
        .credit_ok_c   (credit_ok_c)
    );

    assign word_in_c   = rd_data_valid && (state == ST_WAIT) && (outstanding != '0);
    assign burst_end_c = word_in_c && (outstanding == OUT_W'(1));
    assign frame_end_c = burst_end_c && (word_cnt == WORD_W'(TOTAL - 1));
    assign start_ok_c  = frame_start && enable && !frame_busy &&
                         ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            outstanding <= '0;
            word_cnt    <= '0;
            col_cnt     <= '0;
            line_index  <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            err_extra   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start && frame_busy)
                err_overrun <= 1'b1;
            if (rd_data_valid && !word_in_c)
                err_extra <= 1'b1;

            // Per-word progress; line_index parks on the last line at frame end.
            if (word_in_c) begin
                outstanding <= outstanding - OUT_W'(1);
                word_cnt    <= word_cnt + WORD_W'(1);
                if (col_cnt == COL_W'(HOR_PIX - 1)) begin
                    col_cnt <= '0;
                    if (line_index != 16'(VER_PIX - 1))
                        line_index <= line_index + 16'd1;
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_c) begin
                        state      <= ST_REQ;
                        rd_addr    <= fb_base;
                        word_cnt   <= '0;
                        col_cnt    <= '0;
                        line_index <= '0;
                        frame_busy <= 1'b1;
                        rd_req     <= credit_ok_c;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Once raised, the request holds until accepted.
                    if (rd_req) begin
                        if (rd_ack) begin
                            rd_req      <= 1'b0;
                            outstanding <= OUT_W'(BURST_LEN);
                            state       <= ST_WAIT;
                        end
                    end else begin
                        rd_req <= credit_ok_c;
                    end
                end
                ST_WAIT: begin
                    if (burst_end_c) begin
                        if (frame_end_c) begin
                            state      <= ST_DONE;
                            frame_done <= 1'b1;
                            frame_busy <= 1'b0;
                        end else if (!enable) begin
                            state      <= ST_IDLE;
                            frame_busy <= 1'b0;
                        end else begin
                            state   <= ST_REQ;
                            rd_addr <= rd_addr + ADDR_W'(BURST_LEN);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_line_fetch_ctrl.sv
// Randomised bench for lcd_line_fetch_ctrl with a transaction-level model
// of FIFO occupancy, burst address sequence, frame progress and error flags.
module tb_lcd_line_fetch_ctrl;
    localparam int unsigned HOR   = 32;
    localparam int unsigned VER   = 4;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned BURST = 16;
    localparam int unsigned AW    = 20;
    localparam int unsigned TOTAL = HOR * VER;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk_12mhz = 1'b0;
    logic          rst = 1'b1, enable = 1'b0, frame_start = 1'b0;
    logic [AW-1:0] fb_base = '0;
    logic          rd_req, rd_ack = 1'b0, rd_data_valid = 1'b0, fifo_pop = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] fifo_level;
    logic          buffer_empty, frame_busy, frame_done, err_overrun, err_extra;
    logic [15:0]   line_index, underflow_cnt;

    always #5 clk_12mhz = ~clk_12mhz;

    lcd_line_fetch_ctrl #(
        .HOR_PIX(HOR), .VER_PIX(VER), .FIFO_DEPTH(DEPTH), .BURST_LEN(BURST), .ADDR_W(AW)
    ) dut (
        .clk_12mhz(clk_12mhz), .rst(rst), .enable(enable), .frame_start(frame_start),
        .fb_base(fb_base), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data_valid(rd_data_valid), .fifo_pop(fifo_pop), .fifo_level(fifo_level),
        .buffer_empty(buffer_empty), .frame_busy(frame_busy), .frame_done(frame_done),
        .line_index(line_index), .underflow_cnt(underflow_cnt),
        .err_overrun(err_overrun), .err_extra(err_extra)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model state
    int  m_level = 0, m_under = 0, m_out = 0, m_words = 0;
    bit  m_busy = 0, m_done = 0, m_eov = 0, m_eext = 0;
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] ack_log[$];
    int  done_cnt = 0;

    // Memory responder / pixel writer stimulus knobs
    int  r_out = 0, r_wait = 0;
    bit  r_seen = 0;
    int  ack_fixed = 0, ack_max = 0, dv_pct = 100, pop_mode = 0, pop_pct = 50;
    bit  stray_ack = 0;
    int  f_dv = -1, f_pop = -1;
    int  req_cycles = 0, last_req_cycles = 0;
    bit  p_valid = 0, p_req = 0, p_ack = 0;
    logic [AW-1:0] p_addr = '0;

    task automatic step();
        bit s_req, hs;
        logic [AW-1:0] s_addr, exp_addr;
        int exp_line;
        s_req  = rd_req;
        s_addr = rd_addr;
        if (p_valid && p_req && !p_ack) begin
            chk("req_hold", s_req, 1);
            chk("addr_hold", s_addr, p_addr);
        end
        if (p_valid && !p_req && s_req)
            chk("req_credit", (m_level + BURST <= DEPTH), 1);

        rd_ack = 1'b0;
        if (s_req) begin
            req_cycles++;
            if (!r_seen) begin
                r_seen = 1;
                r_wait = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(ack_max, 0));
            end
            if (r_wait == 0) rd_ack = 1'b1;
            else r_wait--;
        end else if (stray_ack && $urandom_range(9, 0) == 0) begin
            rd_ack = 1'b1;
        end
        rd_data_valid = 1'b0;
        if (f_dv >= 0) rd_data_valid = (f_dv != 0);
        else if (r_out > 0 && int'($urandom_range(99, 0)) < dv_pct) begin
            rd_data_valid = 1'b1;
            r_out--;
        end
        hs = s_req && rd_ack;
        if (hs) begin
            r_out = BURST;
            r_seen = 0;
            last_req_cycles = req_cycles;
            req_cycles = 0;
            ack_log.push_back(s_addr);
        end
        case (pop_mode)
            1:       fifo_pop = (int'($urandom_range(99, 0)) < pop_pct);
            2:       fifo_pop = (m_level >= 16);
            3:       fifo_pop = (m_level > 0);
            default: fifo_pop = 1'b0;
        endcase
        if (f_pop >= 0) fifo_pop = (f_pop != 0);

        @(posedge clk_12mhz);
        if (rst) begin
            m_level = 0; m_under = 0; m_out = 0; m_words = 0;
            m_busy = 0; m_done = 0; m_eov = 0; m_eext = 0;
            addr_q.delete();
            r_out = 0; r_seen = 0; req_cycles = 0;
        end else begin
            m_done = 0;
            if (frame_start && m_busy) m_eov = 1;
            if (frame_start && enable && !m_busy) begin
                m_busy = 1; m_words = 0;
                addr_q.delete();
                for (int k = 0; k < int'(TOTAL / BURST); k++)
                    addr_q.push_back(AW'(fb_base + k * BURST));
            end
            if (rd_data_valid) begin
                if (m_out > 0) begin
                    m_out--; m_words++;
                    if (m_out == 0) begin
                        if (m_words == int'(TOTAL)) begin m_done = 1; m_busy = 0; end
                        else if (!enable) begin m_busy = 0; addr_q.delete(); end
                    end
                end else begin
                    m_eext = 1;
                end
            end
            if (hs) begin
                if (addr_q.size() == 0) chk("burst_expected", 0, 1);
                else begin
                    exp_addr = addr_q.pop_front();
                    chk("burst_addr", s_addr, exp_addr);
                end
                m_out = BURST;
            end
            if (rd_data_valid && !fifo_pop) m_level++;
            else if (!rd_data_valid && fifo_pop) begin
                if (m_level == 0) m_under = (m_under < 65535) ? m_under + 1 : 65535;
                else m_level--;
            end
        end
        p_req = s_req; p_ack = rd_ack; p_addr = s_addr; p_valid = !rst;

        @(negedge clk_12mhz);
        exp_line = m_words / int'(HOR);
        if (exp_line > int'(VER) - 1) exp_line = int'(VER) - 1;
        chk("fifo_level", fifo_level, m_level);
        chk("buffer_empty", buffer_empty, m_level == 0);
        chk("frame_busy", frame_busy, m_busy);
        chk("frame_done", frame_done, m_done);
        chk("line_index", line_index, exp_line);
        chk("underflow_cnt", underflow_cnt, m_under);
        chk("err_overrun", err_overrun, m_eov);
        chk("err_extra", err_extra, m_eext);
        if (!m_busy || m_out > 0) chk("req_when_no_credit_phase", rd_req, 0);
        if (frame_done) done_cnt++;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin step(); n++; end
        if (done_cnt < target) chk("frame_timeout", done_cnt, target);
    endtask

    task automatic drain();
        int n = 0;
        pop_mode = 3;
        while (m_level > 0 && n < 200) begin step(); n++; end
        chk("drain", m_level, 0);
        pop_mode = 0;
        step();
    endtask

    task automatic start_frame(input logic [AW-1:0] base);
        frame_start = 1'b1; fb_base = base;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        int n, acks0, dn0;
        @(negedge clk_12mhz);
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_empty", buffer_empty, 1);
        chk("rst_busy", frame_busy, 0);

        // Immediate ack, full-rate data, no pops: stall at a full FIFO.
        ack_fixed = 0; dv_pct = 100; pop_mode = 0; enable = 1'b1;
        start_frame(20'h01000);
        chk("start_latency", rd_req, 1);
        chk("first_addr", rd_addr, 20'h01000);
        n = 0;
        while (!(ack_log.size() == 4 && m_out == 0) && n < 300) begin step(); n++; end
        repeat (20) step();
        chk("full_level", fifo_level, 64);
        chk("full_no_req", rd_req, 0);
        if (ack_log.size() >= 4) begin
            chk("burst0", ack_log[0], 20'h01000);
            chk("burst1", ack_log[1], 20'h01010);
            chk("burst2", ack_log[2], 20'h01020);
            chk("burst3", ack_log[3], 20'h01030);
        end else chk("burst_count", ack_log.size(), 4);
        pop_mode = 2;
        wait_done(1, 3000);
        chk("t1_line", line_index, VER - 1);
        chk("t1_under", underflow_cnt, 0);
        chk("t1_bursts", ack_log.size(), TOTAL / BURST);
        drain();

        // Five-cycle ack latency holds request and address.
        ack_fixed = 5; pop_mode = 2;
        start_frame(20'h02000);
        wait_done(2, 4000);
        chk("ack_delay_req_cycles", last_req_cycles, 6);
        drain();

        // Pops on an empty FIFO, then pop+valid together.
        f_pop = 1; step(); step(); step();
        f_dv = 1; step();
        f_pop = -1; f_dv = -1;
        chk("underflow3", underflow_cnt, 3);
        chk("underflow_level", fifo_level, 0);
        chk("extra_after_spurious", err_extra, 1);

        // Start while disabled is ignored silently.
        enable = 1'b0;
        start_frame(20'h0AAAA);
        chk("disabled_busy", frame_busy, 0);
        chk("disabled_overrun", err_overrun, 0);

        // Overrun mid-frame leaves the fetch sequence intact.
        enable = 1'b1; ack_fixed = -1; ack_max = 4; dv_pct = 70; pop_mode = 1; pop_pct = 60;
        start_frame(20'h03000);
        repeat (30) step();
        start_frame(20'h07777);
        chk("overrun_set", err_overrun, 1);
        wait_done(3, 4000);
        chk("overrun_done_cnt", done_cnt, 3);

        // Enable dropped mid-burst: finish the burst then idle without frame_done.
        repeat (3) step();
        acks0 = ack_log.size(); dn0 = done_cnt;
        start_frame(20'h04000);
        n = 0;
        while (ack_log.size() == acks0 && n < 200) begin step(); n++; end
        enable = 1'b0;
        repeat (100) step();
        chk("drop_busy", frame_busy, 0);
        chk("drop_no_req", rd_req, 0);
        chk("drop_bursts", ack_log.size() - acks0, 1);
        chk("drop_no_done", done_cnt, dn0);

        // Randomised frames, including a base that wraps the address space.
        enable = 1'b1; stray_ack = 1;
        for (int f = 0; f < 4; f++) begin
            ack_max = int'($urandom_range(6, 0));
            dv_pct  = int'($urandom_range(100, 40));
            pop_pct = int'($urandom_range(90, 30));
            dn0 = done_cnt;
            start_frame((f == 0) ? 20'hFFFC0 : AW'($urandom));
            wait_done(dn0 + 1, 6000);
            chk("rand_line", line_index, VER - 1);
            repeat (3) step();
        end
        stray_ack = 0;

        // Reset while seven words are still outstanding.
        ack_fixed = 0; dv_pct = 100; pop_mode = 3;
        start_frame(20'h05000);
        n = 0;
        while (m_out != 7 && n < 300) begin step(); n++; end
        chk("reached_7_outstanding", m_out, 7);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_req", rd_req, 0);
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_busy", frame_busy, 0);
        chk("mid_rst_line", line_index, 0);
        chk("mid_rst_under", underflow_cnt, 0);
        chk("mid_rst_ovr", err_overrun, 0);
        chk("mid_rst_ext", err_extra, 0);
        pop_mode = 0; f_dv = 1; step(); f_dv = -1;
        chk("post_rst_extra", err_extra, 1);
        chk("post_rst_level", fifo_level, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
